// File: rtl/stream_pkt_gen.sv
// stream_pkt_gen: turns {length, seed} commands into multi-lane beats of an incrementing lane pattern.
// Define STREAM_PKT_GEN_GAP_EN to insert GAP_CYCLES idle clocks after every non-last beat.
module stream_pkt_gen #(
  parameter int T_DATA_WIDTH = 8,
  parameter int KEEP_WIDTH   = 8,
  parameter int LEN_WIDTH    = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [T_DATA_WIDTH-1:0] cmd_seed,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [T_DATA_WIDTH-1:0] m_data_out [KEEP_WIDTH],
  output logic [KEEP_WIDTH-1:0]   m_keep_out,
  output logic                    m_last_out,
  output logic                    m_valid_out,
  input  logic                    m_ready_in,
  output logic                    err_zero_len,
  output logic [15:0]             pkt_cnt
);
  localparam int RW = LEN_WIDTH + 1;
  localparam logic [RW-1:0] KW = RW'(KEEP_WIDTH);
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end
`ifdef STREAM_PKT_GEN_GAP_EN
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  state_t state;
  logic [RW-1:0] rem, src_r, b_rem;
  logic [T_DATA_WIDTH-1:0] base, src_b, b_base;
  logic [T_DATA_WIDTH-1:0] b_data [KEEP_WIDTH];
  logic [KEEP_WIDTH-1:0] b_keep;
  logic b_last, accept, hs, load;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && state == IDLE;
  assign hs = m_valid_out && m_ready_in;
  // The next beat is built from the command in IDLE, otherwise from the running remainder/base.
  always_comb begin
    src_r = state == IDLE ? RW'(cmd_len) : rem;
    src_b = state == IDLE ? cmd_seed : base;
    b_last = src_r <= KW;
    b_rem = b_last ? '0 : src_r - KW;
    b_base = src_b + T_DATA_WIDTH'(KEEP_WIDTH);
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      b_keep[i] = src_r > RW'(i);
      b_data[i] = b_keep[i] ? src_b + T_DATA_WIDTH'(i) : '0;
    end
`ifdef STREAM_PKT_GEN_GAP_EN
    load = (accept && cmd_len != '0) || (state == GAP && gap_cnt == '0);
`else
    load = (accept && cmd_len != '0) || (hs && !m_last_out);
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      base <= '0;
      m_valid_out <= 1'b0;
      m_last_out <= 1'b0;
      m_keep_out <= '0;
      m_data_out <= '{default: '0};
      err_zero_len <= 1'b0;
      pkt_cnt <= '0;
`ifdef STREAM_PKT_GEN_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      err_zero_len <= accept && cmd_len == '0;
      if (hs && m_last_out) pkt_cnt <= pkt_cnt + 16'd1;
      if (load) begin
        state <= SEND;
        m_valid_out <= 1'b1;
        m_data_out <= b_data;
        m_keep_out <= b_keep;
        m_last_out <= b_last;
        rem <= b_rem;
        base <= b_base;
      end else if (hs) begin
        m_valid_out <= 1'b0;
        m_last_out <= 1'b0;
`ifdef STREAM_PKT_GEN_GAP_EN
        state <= m_last_out ? IDLE : GAP;
        gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
`else
        state <= IDLE;
`endif
      end
    end
  end
endmodule

// File: tb/tb_stream_pkt_gen.sv
// tb_stream_pkt_gen: directed commands with hand-computed beats, checked by a queue-driven output monitor.
module tb_stream_pkt_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cmd_len = '0;
  logic [7:0] cmd_seed = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [7:0] m_data_out [8];
  logic [7:0] m_keep_out;
  logic m_last_out, m_valid_out, err_zero_len;
  logic m_ready_in = 1'b1;
  logic [15:0] pkt_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  stream_pkt_gen dut (
    .clk(clk), .rst_n(rst_n), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .m_data_out(m_data_out),
    .m_keep_out(m_keep_out), .m_last_out(m_last_out), .m_valid_out(m_valid_out),
    .m_ready_in(m_ready_in), .err_zero_len(err_zero_len), .pkt_cnt(pkt_cnt)
  );

  function automatic logic [63:0] packed_data();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = m_data_out[i];
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    exp_q.push_back('{data: d, keep: k, last: l});
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && m_valid_out && m_ready_in) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", packed_data(), e.data);
        check("beat_keep", m_keep_out, e.keep);
        check("beat_last", m_last_out, e.last);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed);
    int t = 0;
    cmd_len = len;
    cmd_seed = seed;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin
      cyc();
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!m_valid_out && t < 50) begin
      cyc();
      t++;
    end
    check({name, "_valid_seen"}, m_valid_out, 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((m_valid_out || exp_q.size() != 0) && t < 200) begin
      cyc();
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] sd;
    logic [7:0] sk;
    logic sl;
    logic [15:0] c0;
    logic [8:0] trace;
    repeat (3) cyc();
    rst_n = 1'b1;
    check("rst_valid", m_valid_out, 0);
    check("rst_last", m_last_out, 0);
    check("rst_keep", m_keep_out, 0);
    check("rst_data", packed_data(), 0);
    check("rst_err", err_zero_len, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    // single full beat: latency 1, then one bubble
    push(64'h17161514_13121110, 8'hFF, 1'b1);
    send_cmd(16'd8, 8'h10);
    check("t1_valid", m_valid_out, 1);
    check("t1_last", m_last_out, 1);
    cyc();
    check("t1_valid_after", m_valid_out, 0);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_cmd_ready", cmd_ready, 1);
    // partial last beat with data wrap
    push(64'h05040302_0100FFFE, 8'hFF, 1'b0);
    push(64'h00000000_00080706, 8'h07, 1'b1);
    send_cmd(16'd11, 8'hFE);
    wait_idle("t2");
    check("t2_pkt_cnt", pkt_cnt, 2);
    // stall on beat 2
    push(64'h07060504_03020100, 8'hFF, 1'b0);
    push(64'h0F0E0D0C_0B0A0908, 8'hFF, 1'b0);
    push(64'h00000000_13121110, 8'h0F, 1'b1);
    send_cmd(16'd20, 8'h00);
    cyc();
    wait_valid("t3");
    m_ready_in = 1'b0;
    sd = packed_data();
    sk = m_keep_out;
    sl = m_last_out;
    check("t3_stall_keep", sk, 8'hFF);
    check("t3_stall_last", sl, 0);
    repeat (5) begin
      cyc();
      check("t3_hold_valid", m_valid_out, 1);
      check("t3_hold_data", packed_data(), sd);
      check("t3_hold_keep", m_keep_out, sk);
      check("t3_hold_last", m_last_out, sl);
    end
    m_ready_in = 1'b1;
    wait_idle("t3");
    check("t3_pkt_cnt", pkt_cnt, 3);
    // zero-length command
    c0 = pkt_cnt;
    check("t4_err_before", err_zero_len, 0);
    send_cmd(16'd0, 8'h55);
    check("t4_err_pulse", err_zero_len, 1);
    check("t4_no_valid", m_valid_out, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    cyc();
    check("t4_err_clear", err_zero_len, 0);
    check("t4_no_valid_after", m_valid_out, 0);
    check("t4_pkt_cnt", pkt_cnt, c0);
    // reset during beat 2
    push(64'h27262524_23222120, 8'hFF, 1'b0);
    send_cmd(16'd24, 8'h20);
    cyc();
    wait_valid("t5");
    m_ready_in = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("t5_valid", m_valid_out, 0);
    check("t5_pkt_cnt", pkt_cnt, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_queue", exp_q.size(), 0);
    m_ready_in = 1'b1;
    push(64'h00000000_00424140, 8'h07, 1'b1);
    send_cmd(16'd3, 8'h40);
    wait_idle("t5");
    check("t5_pkt_cnt_after", pkt_cnt, 1);
    // beat spacing
    push(64'h87868584_83828180, 8'hFF, 1'b0);
    push(64'h8F8E8D8C_8B8A8988, 8'hFF, 1'b0);
    push(64'h97969594_93929190, 8'hFF, 1'b1);
    send_cmd(16'd24, 8'h80);
    for (int i = 0; i < 9; i++) begin
      trace[i] = m_valid_out;
      cyc();
    end
`ifdef STREAM_PKT_GEN_GAP_EN
    check("t6_valid_trace", trace, 9'b001001001);
`else
    check("t6_valid_trace", trace, 9'b000000111);
`endif
    wait_idle("t6");
    check("t6_pkt_cnt", pkt_cnt, 2);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule
